// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: NUM_PE fixed-point MAC lanes that stream
// weights/biases from a synchronous memory and emit activated output groups.
module dense_layer_engine #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRAC_BITS     = 8,
    parameter int ACC_WIDTH     = 40,
    parameter int NUM_IN        = 2,
    parameter int NUM_OUT       = 32,
    parameter int NUM_PE        = 4,
    parameter int ADDRESS_WIDTH = 10,
    parameter int ACT_MODE      = 2,
    parameter int ALPHA_SHIFT   = 3,
    localparam int NUM_GROUPS   = NUM_OUT / NUM_PE,
    localparam int GROUP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_in_valid,
    input  logic [DATA_WIDTH-1:0]        i_in_data,
    output logic                         o_in_ready,
    output logic [ADDRESS_WIDTH-1:0]     o_w_addr,
    output logic                         o_w_en,
    input  logic [NUM_PE*DATA_WIDTH-1:0] i_w_data,
    output logic                         o_out_valid,
    output logic [NUM_PE*DATA_WIDTH-1:0] o_out_data,
    output logic [GROUP_W-1:0]           o_out_index,
    input  logic                         i_out_ready,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int CNT_W = $clog2(NUM_IN + 2);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_ACT,
        S_OUT,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [GROUP_W-1:0]            g_q, g_d;
    logic [DATA_WIDTH-1:0]         buf_q [NUM_IN];
    logic [DATA_WIDTH-1:0]         buf_d [NUM_IN];
    logic signed [ACC_WIDTH-1:0]   acc_q [NUM_PE];
    logic signed [ACC_WIDTH-1:0]   acc_d [NUM_PE];
    logic [NUM_PE*DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [GROUP_W-1:0]            out_index_q, out_index_d;

    logic [DATA_WIDTH-1:0]           sel_in;
    logic signed [DATA_WIDTH-1:0]    lane_w    [NUM_PE];
    logic signed [2*DATA_WIDTH-1:0]  lane_prod [NUM_PE];
    logic signed [ACC_WIDTH-1:0]     term      [NUM_PE];
    logic signed [ACC_WIDTH-1:0]     shifted   [NUM_PE];
    logic signed [DATA_WIDTH-1:0]    lane_sat  [NUM_PE];
    logic signed [DATA_WIDTH-1:0]    lane_act  [NUM_PE];
    logic [NUM_PE*DATA_WIDTH-1:0]    act_data;

    // Read data in MAC cycle cnt belongs to row cnt-1; row NUM_IN is the bias row.
    always_comb begin
        sel_in = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (cnt_q == CNT_W'(k + 1)) begin
                sel_in = buf_q[k];
            end
        end
        for (int p = 0; p < NUM_PE; p++) begin
            lane_w[p]    = i_w_data[p*DATA_WIDTH +: DATA_WIDTH];
            lane_prod[p] = $signed(sel_in) * lane_w[p];
            if (cnt_q == CNT_W'(NUM_IN + 1)) begin
                term[p] = {{(ACC_WIDTH-DATA_WIDTH-FRAC_BITS){lane_w[p][DATA_WIDTH-1]}},
                           lane_w[p], {FRAC_BITS{1'b0}}};
            end else begin
                term[p] = {{(ACC_WIDTH-2*DATA_WIDTH){lane_prod[p][2*DATA_WIDTH-1]}},
                           lane_prod[p]};
            end
        end
    end

    always_comb begin
        act_data = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            shifted[p] = acc_q[p] >>> FRAC_BITS;
            if (shifted[p] > SAT_MAX) begin
                lane_sat[p] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else if (shifted[p] < SAT_MIN) begin
                lane_sat[p] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            end else begin
                lane_sat[p] = shifted[p][DATA_WIDTH-1:0];
            end
            lane_act[p] = lane_sat[p];
            if (lane_sat[p][DATA_WIDTH-1]) begin
                if (ACT_MODE == 1) begin
                    lane_act[p] = '0;
                end else if (ACT_MODE == 2) begin
                    lane_act[p] = lane_sat[p] >>> ALPHA_SHIFT;
                end
            end
            act_data[p*DATA_WIDTH +: DATA_WIDTH] = lane_act[p];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        g_d         = g_q;
        buf_d       = buf_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (i_in_valid) begin
                    for (int k = 0; k < NUM_IN; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            buf_d[k] = i_in_data;
                        end
                    end
                    if (cnt_q == CNT_W'(NUM_IN - 1)) begin
                        cnt_d   = '0;
                        g_d     = '0;
                        state_d = S_MAC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                for (int p = 0; p < NUM_PE; p++) begin
                    acc_d[p] = (cnt_q == '0) ? '0 : acc_q[p] + term[p];
                end
                if (cnt_q == CNT_W'(NUM_IN + 1)) begin
                    cnt_d   = '0;
                    state_d = S_ACT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACT: begin
                out_data_d  = act_data;
                out_index_d = g_q;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (i_out_ready) begin
                    if (g_q == GROUP_W'(NUM_GROUPS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        g_d     = g_q + 1'b1;
                        state_d = S_MAC;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            g_q         <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            for (int k = 0; k < NUM_IN; k++) begin
                buf_q[k] <= '0;
            end
            for (int p = 0; p < NUM_PE; p++) begin
                acc_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            buf_q       <= buf_d;
            acc_q       <= acc_d;
        end
    end

    always_comb begin
        o_w_en      = (state_q == S_MAC) && (cnt_q <= CNT_W'(NUM_IN));
        o_w_addr    = '0;
        if (o_w_en) begin
            o_w_addr = ADDRESS_WIDTH'(g_q) * ADDRESS_WIDTH'(NUM_IN + 1) + ADDRESS_WIDTH'(cnt_q);
        end
        o_in_ready  = (state_q == S_LOAD);
        o_out_valid = (state_q == S_OUT);
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_DONE);
        o_out_data  = out_data_q;
        o_out_index = out_index_q;
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench: three engines (one per activation mode) share stimulus and a weight
// memory; a monitor pops expected groups from a queue on every accepted output.
module tb_dense_layer_engine;

    localparam int DW  = 16;
    localparam int FB  = 8;
    localparam int NI  = 2;
    localparam int NO  = 4;
    localparam int NP  = 2;
    localparam int ADW = 10;
    localparam int AS  = 3;
    localparam int G   = NO / NP;
    localparam int GW  = 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic in_valid;
    logic [DW-1:0] in_data;
    logic [NP*DW-1:0] w_data = '0;
    logic out_ready;

    logic            in_ready  [3];
    logic [ADW-1:0]  w_addr    [3];
    logic            w_en      [3];
    logic            out_valid [3];
    logic [NP*DW-1:0] out_data [3];
    logic [GW-1:0]   out_index [3];
    logic            busy      [3];
    logic            done      [3];

    typedef struct packed {
        logic [GW-1:0]         g;
        logic [2:0][NP*DW-1:0] d;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [NP*DW-1:0] mem [0:(1<<ADW)-1];
    logic [DW-1:0] in_vec [NI];
    int tests = 0;
    int fails = 0;
    int done_count = 0;
    int ready_mode = 1;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        dense_layer_engine #(
            .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(40), .NUM_IN(NI),
            .NUM_OUT(NO), .NUM_PE(NP), .ADDRESS_WIDTH(ADW), .ACT_MODE(m),
            .ALPHA_SHIFT(AS)
        ) u_dut (
            .clk(clk), .rst(rst), .i_start(start), .i_in_valid(in_valid),
            .i_in_data(in_data), .o_in_ready(in_ready[m]), .o_w_addr(w_addr[m]),
            .o_w_en(w_en[m]), .i_w_data(w_data), .o_out_valid(out_valid[m]),
            .o_out_data(out_data[m]), .o_out_index(out_index[m]),
            .i_out_ready(out_ready), .o_busy(busy[m]), .o_done(done[m])
        );
    end

    always @(posedge clk) begin
        if (w_en[0]) w_data <= mem[w_addr[0]];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: full-precision dot product plus scaled bias, wrapped to 40 bits,
    // floor-shifted, saturated to 16 bits, then the mode's negative-side rule.
    function automatic logic [DW-1:0] modelLane(input int g, input int p, input int m);
        longint acc = 0;
        longint r;
        for (int k = 0; k < NI; k++) begin
            acc += longint'($signed(in_vec[k])) * longint'($signed(mem[g*(NI+1)+k][p*DW +: DW]));
        end
        acc += longint'($signed(mem[g*(NI+1)+NI][p*DW +: DW])) * 256;
        acc = (acc <<< 24) >>> 24;
        r = acc >>> FB;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (r < 0) begin
            if (m == 1) r = 0;
            else if (m == 2) r = r >>> AS;
        end
        return r[DW-1:0];
    endfunction

    task automatic setRow(input int g, input int k, input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        mem[g*(NI+1)+k] = {l1, l0};
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("%s_mode%0d", tag, m),
                {in_ready[m], w_en[m], out_valid[m], busy[m], done[m],
                 w_addr[m], out_data[m], out_index[m]}, 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done[0]) done_count++;
            if (out_valid[0] && out_ready) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_group", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    checkOutput("out_index", 64'(out_index[0]), 64'(mon_e.g));
                    for (int m = 0; m < 3; m++) begin
                        checkOutput($sformatf("valid_mode%0d", m), 64'(out_valid[m]), 64'd1);
                        checkOutput($sformatf("data_mode%0d_g%0d", m, mon_e.g),
                                    64'(out_data[m]), 64'(mon_e.d[m]));
                    end
                end
            end
        end
    end

    // Pushes the expected groups, then drives start and the input vector.
    task automatic applyStimulus(input bit gaps, input bit spurious);
        exp_t e;
        for (int g = 0; g < G; g++) begin
            e.g = GW'(g);
            for (int m = 0; m < 3; m++)
                for (int p = 0; p < NP; p++)
                    e.d[m][p*DW +: DW] = modelLane(g, p, m);
            sbq.push_back(e);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid = 1'b1;
            in_data  = in_vec[k];
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = '0;
            if (gaps && k == 0) repeat (2) begin @(posedge clk); #1; end
        end
        if (spurious) begin
            in_valid = 1'b1;
            in_data  = 16'h7777;
            start    = 1'b1;
            repeat (2) begin @(posedge clk); #1; end
            in_valid = 1'b0;
            in_data  = '0;
            start    = 1'b0;
        end
    endtask

    task automatic waitDone();
        int prev = done_count;
        int n = 0;
        while (done_count == prev && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_timeout", 64'(done_count == prev), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", 64'(done_count - prev), 64'd1);
        checkOutput("sb_empty", 64'(sbq.size()), 64'd0);
        checkOutput("idle_after_done", 64'(busy[0]), 64'd0);
        sbq.delete();
    endtask

    task automatic loadBasic();
        in_vec[0] = 16'h0100;
        in_vec[1] = 16'h0200;
        setRow(0, 0, 16'h0080, 16'hFF00);
        setRow(0, 1, 16'h0040, 16'h0100);
        setRow(0, 2, 16'h0020, 16'h0000);
        setRow(1, 0, 16'h0100, 16'h0080);
        setRow(1, 1, 16'h0000, 16'hFFC0);
        setRow(1, 2, 16'hFFF0, 16'h0040);
    endtask

    initial begin
        logic [NP*DW-1:0] held_d;
        logic [GW-1:0] held_i;
        int n;
        for (int a = 0; a < (1 << ADW); a++) mem[a] = '0;
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        #1;
        checkResetOutputs("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        loadBasic();
        applyStimulus(0, 0);
        waitDone();

        in_vec[0] = 16'h0100;
        in_vec[1] = 16'h0200;
        for (int g = 0; g < G; g++) begin
            setRow(g, 0, 16'hFF00, 16'hFF00);
            setRow(g, 1, 16'hFF00, 16'hFF00);
            setRow(g, 2, 16'h0000, 16'h0000);
        end
        applyStimulus(0, 0);
        waitDone();

        in_vec[0] = 16'h7FFF;
        in_vec[1] = 16'h7FFF;
        setRow(0, 0, 16'h7FFF, 16'h7FFF);
        setRow(0, 1, 16'h7FFF, 16'h7FFF);
        setRow(0, 2, 16'h0000, 16'h7FFF);
        setRow(1, 0, 16'h8000, 16'h8000);
        setRow(1, 1, 16'h8000, 16'h8000);
        setRow(1, 2, 16'h0000, 16'h8000);
        applyStimulus(0, 0);
        waitDone();

        // Backpressure on group 0, then the accept-to-next-group period.
        loadBasic();
        ready_mode = 0;
        applyStimulus(0, 0);
        n = 0;
        while (!out_valid[0] && n < 100) begin @(negedge clk); n++; end
        checkOutput("stall_reach_valid", 64'(out_valid[0]), 64'd1);
        held_d = out_data[0];
        held_i = out_index[0];
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("stall_valid", 64'(out_valid[0]), 64'd1);
            checkOutput("stall_data", 64'(out_data[0]), 64'(held_d));
            checkOutput("stall_index", 64'(out_index[0]), 64'(held_i));
            checkOutput("stall_w_en", 64'(w_en[0]), 64'd0);
        end
        @(posedge clk); #1 ready_mode = 1;
        @(posedge clk);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid[0] && n < 50);
        checkOutput("group_period", 64'(n), 64'(NI + 4));
        waitDone();

        applyStimulus(1, 1);
        waitDone();

        // Asynchronous reset in the MAC phase of group 1, then a clean rerun.
        applyStimulus(0, 0);
        n = 0;
        while (sbq.size() != G - 1 && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!w_en[0] && n < 100) begin @(negedge clk); n++; end
        checkOutput("reached_mac_g1", 64'(w_en[0]), 64'd1);
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("reset_mid_mac");
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("post_reset_valid", 64'(out_valid[0]), 64'd0);
        end
        applyStimulus(0, 0);
        waitDone();

        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NI; k++) in_vec[k] = 16'($urandom);
            for (int a = 0; a < G * (NI + 1); a++) mem[a] = 32'($urandom);
            applyStimulus(r[0], (r % 3) == 0);
            waitDone();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dense_layer_engine.md
# dense_layer_engine

Time-multiplexed, parametrised fully-connected layer for the DQN datapath. It replaces one MAC node per output with NUM_PE parallel fixed-point MAC lanes. The block buffers one input vector, streams weights and biases from an external synchronous memory, and applies a selectable activation (none / ReLU / leaky ReLU). Results leave on a valid/ready stream rather than a file dump. It chains hidden and output layers of both the policy and the target networks.

## Interface
- DATA_WIDTH, 16: signed fixed-point width of inputs, weights, biases and outputs.
- FRAC_BITS, 8: fractional bits of every DATA_WIDTH value.
- ACC_WIDTH, 40: signed accumulator width; must be ≥ 2·DATA_WIDTH + clog2(NUM_IN+1).
- NUM_IN, 2: input nodes per vector, ≥1.
- NUM_OUT, 32: output nodes; must be a multiple of NUM_PE.
- NUM_PE, 4: parallel MAC lanes, ≥1.
- ADDRESS_WIDTH, 10: weight memory address width.
- ACT_MODE, 2: 0 = none, 1 = ReLU, 2 = leaky ReLU.
- ALPHA_SHIFT, 3: leaky slope is 2^-ALPHA_SHIFT.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  starts one layer evaluation; sampled only in IDLE.
- i_in_valid  in  1  input element valid.
- i_in_data  in  DATA_WIDTH  input element, delivered in index order 0..NUM_IN-1.
- o_in_ready  out  1  high only in LOAD.
- o_w_addr  out  ADDRESS_WIDTH  weight memory read address.
- o_w_en  out  1  weight read strobe.
- i_w_data  in  NUM_PE·DATA_WIDTH  read data, returned 1 cycle after o_w_en; lane p occupies [p·DATA_WIDTH +: DATA_WIDTH].
- o_out_valid  out  1  output group valid.
- o_out_data  out  NUM_PE·DATA_WIDTH  activated results; lane p is node o_out_index·NUM_PE+p.
- o_out_index  out  clog2(NUM_OUT/NUM_PE) (min 1)  group index g.
- i_out_ready  in  1  downstream accept.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the layer completes.

## Operation
- Weight memory layout: group g, row k is at address g·(NUM_IN+1)+k. Rows k<NUM_IN hold weights for input k. Row NUM_IN holds the biases.
- FSM states: IDLE, LOAD, MAC, ACT, OUT, DONE.
- IDLE → LOAD on i_start.
- LOAD: each i_in_valid&o_in_ready beat writes buffer[cnt] and increments cnt. After beat NUM_IN-1: clear cnt, set g=0, go to MAC.
- MAC: issue cycles k=0..NUM_IN, with o_w_en=1 and o_w_addr = g·(NUM_IN+1)+k. This is followed by one drain cycle with o_w_en=0, then ACT. Total is NUM_IN+2 cycles.
- On each cycle where the read data returned for row k is valid:
  - k<NUM_IN: acc_p += sext(buffer[k] · w_p) in signed full precision.
  - k=NUM_IN: acc_p += sext(bias_p) << FRAC_BITS.
- Accumulators clear on MAC entry.
- ACT (1 cycle), per lane:
  - r = acc_p >>> FRAC_BITS (arithmetic, floor).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If negative: mode 1 gives 0; mode 2 gives r >>> ALPHA_SHIFT.
  - Register the result into o_out_data, set o_out_index = g, go to OUT.
- OUT: o_out_valid=1. When i_out_ready: if g = NUM_OUT/NUM_PE-1, go to DONE; else g++ and go to MAC.
- DONE: o_done=1 for exactly one cycle, then IDLE. The input buffer is retained but not reused.

## Timing
- Reset values: o_in_ready, o_w_en, o_out_valid, o_busy, o_done = 0; o_w_addr, o_out_data, o_out_index = 0. FSM in IDLE, counters 0.
- Reset is asserted asynchronously at any point, including mid-MAC or during an OUT stall. It forces the reset values immediately. No partial result is emitted afterwards.
- i_start outside IDLE is ignored. This includes the DONE cycle.
- i_in_valid outside LOAD is ignored. LOAD tolerates gaps of any length.
- OUT stall: o_out_valid, o_out_data and o_out_index hold stable. No weight reads are issued while stalled.
- Latency:
  - i_start → first o_in_ready: 1 cycle.
  - Last input beat → first o_out_valid: NUM_IN+3 cycles.
  - Group period with i_out_ready held high: NUM_IN+4 cycles.
  - Final accept → o_done: 1 cycle.
- Accumulation wraps modulo 2^ACC_WIDTH. Saturation is applied only at ACT.

## Test plan
- Basic (NUM_IN=2, NUM_OUT=4, NUM_PE=2, ACT_MODE=0):
  - Inputs 0x0100, 0x0200; lane-0 weights 0x0080, 0x0040, bias 0x0020 → lane 0 = 0x0120.
  - Exactly 2 groups, o_out_index 0 then 1, single o_done pulse.
- Activation: lane weights 0xFF00, 0xFF00, bias 0 with the same inputs:
  - ACT_MODE=0 → 0xFD00.
  - ACT_MODE=1 → 0x0000.
  - ACT_MODE=2 → 0xFFA0.
- Saturation: inputs 0x7FFF, 0x7FFF; weights 0x7FFF, 0x7FFF → 0x7FFF. With weights 0x8000 → 0x8000.
- Backpressure: i_out_ready low for 5 cycles on group 0 → output stable, o_w_en=0 throughout. Group 1 appears NUM_IN+4 cycles after the accept.
- Input gaps and spurious controls: i_in_valid toggled 1-0-0-1 → the same result as gap-free input. i_start pulsed during MAC → no restart.
- Reset mid-MAC of group 1 → all outputs 0 immediately. A fresh run then yields results identical to the basic case.
